cw_bank_sequencer: RTL and testbench

- Parametrised control-word entry and single-step unit for board-level datapath bring-up.
- Builds an arbitrary-width control word from banked board switches into a live staging register.
- Commits the staged word to the datapath on a debounced step button or an automatic run timer, using a valid/ready handshake.
- Sits between the board switches/KEYs and the datapath under test; replaces fixed 32-bit switch expansion and raw button clocking.

---
 rtl/cw_bank_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_cw_bank_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cw_bank_sequencer.sv
// -----------------------------------------------------------------------------
// cw_bank_sequencer
//
// Control-word entry and single-step unit for board-level datapath bring-up.
// A wide control word is assembled bank by bank from the board switches into
// a live staging register. A debounced step button or an automatic run timer
// commits the staged word to the datapath through a valid/ready handshake.
//
// Ports
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   sw_i            raw switches: [BANK_BITS-1:0] bank data, upper SEL_BITS
//                   bank select
//   step_btn_ni     raw step button, active-low, asynchronous to clk_i
//   run_i           raw run-mode switch (1 = auto-step)
//   clear_ovr_i     synchronous clear of the overrun flag
//   cw_ready_i      datapath accepts the committed word
//   control_word_o  last committed word
//   cw_valid_o      control_word_o is waiting to be accepted
//   staged_word_o   live staging register, for display
//   bank_sel_o      synchronised bank select, for display
//   step_count_o    number of accepted commits, wraps at 2^16
//   overrun_o       sticky: a commit request was dropped
// -----------------------------------------------------------------------------
module cw_bank_sequencer #(
  parameter int CW_WIDTH        = 33,
  parameter int BANK_BITS       = 8,
  parameter int SEL_BITS        = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RUN_PERIOD      = 25000000
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [BANK_BITS+SEL_BITS-1:0] sw_i,
  input  logic                          step_btn_ni,
  input  logic                          run_i,
  input  logic                          clear_ovr_i,
  input  logic                          cw_ready_i,
  output logic [CW_WIDTH-1:0]           control_word_o,
  output logic                          cw_valid_o,
  output logic [CW_WIDTH-1:0]           staged_word_o,
  output logic [SEL_BITS-1:0]           bank_sel_o,
  output logic [15:0]                   step_count_o,
  output logic                          overrun_o
);

  localparam int SW_W      = BANK_BITS + SEL_BITS;
  localparam int NUM_BANKS = (CW_WIDTH + BANK_BITS - 1) / BANK_BITS;
  localparam int DEB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RUN_W     = $clog2(RUN_PERIOD);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_PERIOD - 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers for everything coming from the board
  // ---------------------------------------------------------------------------
  logic [SW_W-1:0] sw_s1_q, sw_s2_q;
  logic            btn_s1_q, btn_s2_q;
  logic            run_s1_q, run_s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
    end else begin
      sw_s1_q  <= sw_i;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= step_btn_ni;
      btn_s2_q <= btn_s1_q;
      run_s1_q <= run_i;
      run_s2_q <= run_s1_q;
    end
  end

  logic [BANK_BITS-1:0] sw_data;
  logic [SEL_BITS-1:0]  bank_sel_s;

  assign sw_data    = sw_s2_q[BANK_BITS-1:0];
  assign bank_sel_s = sw_s2_q[SW_W-1:BANK_BITS];

  // ---------------------------------------------------------------------------
  // Staging register: the selected bank is overwritten every cycle. The top
  // bank is narrower when CW_WIDTH is not a multiple of BANK_BITS, so its
  // excess data bits never land anywhere. Select values with no matching
  // bank match no generate branch and leave the register untouched.
  // ---------------------------------------------------------------------------
  logic [CW_WIDTH-1:0] staged_q, staged_d;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    localparam int LO = gi * BANK_BITS;
    localparam int W  = ((CW_WIDTH - LO) < BANK_BITS) ? (CW_WIDTH - LO) : BANK_BITS;
    assign staged_d[LO +: W] = (bank_sel_s == SEL_BITS'(gi)) ? sw_data[W-1:0]
                                                             : staged_q[LO +: W];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      staged_q <= '0;
    end else begin
      staged_q <= staged_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Button debouncer FSM. The counter restarts on every state entry, so a
  // level is only accepted after DEBOUNCE_CYCLES consecutive samples inside
  // the debounce state. The press request fires once, on the DEB_PRESS->HELD
  // transition, so holding or bouncing cannot produce a second request.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_HELD        = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } btn_state_e;

  btn_state_e       state_q, state_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             press_req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      deb_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    press_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!btn_s2_q) begin
          state_d   = ST_DEB_PRESS;
          deb_cnt_d = '0;
        end
      end
      ST_DEB_PRESS: begin
        if (btn_s2_q) begin
          state_d   = ST_IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = ST_HELD;
          deb_cnt_d = '0;
          press_req = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      ST_HELD: begin
        if (btn_s2_q) begin
          state_d   = ST_DEB_RELEASE;
          deb_cnt_d = '0;
        end
      end
      ST_DEB_RELEASE: begin
        if (!btn_s2_q) begin
          state_d   = ST_HELD;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = ST_IDLE;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        deb_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Run timer: free-runs while run is high, parked at zero otherwise
  // ---------------------------------------------------------------------------
  logic [RUN_W-1:0] run_cnt_q;
  logic             timer_req;

  assign timer_req = run_s2_q && (run_cnt_q == RUN_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_cnt_q <= '0;
    end else if (!run_s2_q || timer_req) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_q + RUN_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Commit and handshake. Button and timer requests landing together are one
  // request. A request is accepted when the output slot is free or is being
  // consumed this very cycle; otherwise it is dropped and flagged.
  // ---------------------------------------------------------------------------
  logic                commit_req, commit_take, commit_drop;
  logic [CW_WIDTH-1:0] control_word_q;
  logic                cw_valid_q;
  logic [15:0]         step_count_q;
  logic                overrun_q;

  assign commit_req  = press_req | timer_req;
  assign commit_take = commit_req & (~cw_valid_q | cw_ready_i);
  assign commit_drop = commit_req & cw_valid_q & ~cw_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      control_word_q <= '0;
      cw_valid_q     <= 1'b0;
      step_count_q   <= '0;
      overrun_q      <= 1'b0;
    end else begin
      if (commit_take) begin
        control_word_q <= staged_q;
        cw_valid_q     <= 1'b1;
        step_count_q   <= step_count_q + 16'd1;
      end else if (cw_valid_q && cw_ready_i) begin
        cw_valid_q <= 1'b0;
      end

      // a drop in the same cycle as a clear keeps the flag set
      if (commit_drop) begin
        overrun_q <= 1'b1;
      end else if (clear_ovr_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign control_word_o = control_word_q;
  assign cw_valid_o     = cw_valid_q;
  assign staged_word_o  = staged_q;
  assign bank_sel_o     = bank_sel_s;
  assign step_count_o   = step_count_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_cw_bank_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for cw_bank_sequencer (CW_WIDTH=33, BANK_BITS=8, SEL_BITS=3,
// DEBOUNCE_CYCLES=4, RUN_PERIOD=8). The reference model describes the
// debouncer as "accepted level + length of the current run of identical
// samples" and the run timer as "length of the current run of run=1 samples",
// rather than as a state machine.
// -----------------------------------------------------------------------------
module tb_cw_bank_sequencer;

  localparam int CW   = 33;
  localparam int BB   = 8;
  localparam int SB   = 3;
  localparam int DEB  = 4;
  localparam int RP   = 8;
  localparam int NB   = 5;
  localparam int SWW  = BB + SB;
  localparam logic [63:0] CW_MASK = (64'd1 << CW) - 64'd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [SWW-1:0] sw;
  logic           btn_n, run, clr, rdy;
  logic [CW-1:0]  cw_o, staged_o;
  logic           valid_o, ovr_o;
  logic [SB-1:0]  sel_o;
  logic [15:0]    cnt_o;

  cw_bank_sequencer #(
    .CW_WIDTH(CW), .BANK_BITS(BB), .SEL_BITS(SB),
    .DEBOUNCE_CYCLES(DEB), .RUN_PERIOD(RP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .sw_i(sw), .step_btn_ni(btn_n), .run_i(run),
    .clear_ovr_i(clr), .cw_ready_i(rdy), .control_word_o(cw_o),
    .cw_valid_o(valid_o), .staged_word_o(staged_o), .bank_sel_o(sel_o),
    .step_count_o(cnt_o), .overrun_o(ovr_o)
  );

  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [SWW-1:0] m_sw1, m_sw2;
  logic           m_btn1, m_btn2, m_run1, m_run2;
  logic [63:0]    m_staged, m_cw;
  bit             m_pressed, m_valid, m_ovr, m_preq, m_treq;
  logic           m_prev;
  int             m_blen, m_rlen, m_cnt;

  function automatic void model_reset();
    m_sw1 = '0; m_sw2 = '0; m_btn1 = 1'b0; m_btn2 = 1'b0; m_run1 = 1'b0; m_run2 = 1'b0;
    m_staged = '0; m_cw = '0; m_pressed = 0; m_valid = 0; m_ovr = 0;
    m_preq = 0; m_treq = 0; m_prev = 1'b1; m_blen = 0; m_rlen = 0; m_cnt = 0;
  endfunction

  // one clock edge, using the input values present before the edge
  function automatic void model_step();
    logic        s;
    bit          req, drop;
    int          sel;
    logic [63:0] data;
    // debouncer: a level is accepted once DEB+1 identical samples in a row
    // oppose the currently accepted level
    s = m_btn2;
    if (s == m_prev) m_blen++; else m_blen = 1;
    m_prev = s;
    m_preq = 0;
    if (!m_pressed && !s && m_blen == DEB + 1) begin
      m_preq = 1;
      m_pressed = 1;
    end else if (m_pressed && s && m_blen == DEB + 1) begin
      m_pressed = 0;
    end
    // run timer: every RP-th consecutive run sample requests a commit
    if (m_run2) m_rlen++; else m_rlen = 0;
    m_treq = m_run2 && (m_rlen % RP == 0);
    req  = m_preq || m_treq;
    drop = req && m_valid && !rdy;
    if (req && !drop) begin
      m_cw = m_staged;
      m_valid = 1;
      m_cnt = (m_cnt + 1) % 65536;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (drop) m_ovr = 1; else if (clr) m_ovr = 0;
    // staging
    sel  = int'(m_sw2[SWW-1:BB]);
    data = 64'(m_sw2[BB-1:0]);
    if (sel < NB)
      m_staged = ((m_staged & ~(64'hFF << (BB * sel))) | (data << (BB * sel))) & CW_MASK;
    m_sw2 = m_sw1; m_sw1 = sw;
    m_btn2 = m_btn1; m_btn1 = btn_n;
    m_run2 = m_run1; m_run1 = run;
  endfunction

  function automatic void check_model();
    chk("control_word", 64'(cw_o), m_cw);
    chk("cw_valid", 64'(valid_o), 64'(m_valid));
    chk("staged_word", 64'(staged_o), m_staged);
    chk("bank_sel", 64'(sel_o), 64'(m_sw2[SWW-1:BB]));
    chk("step_count", 64'(cnt_o), 64'(m_cnt));
    chk("overrun", 64'(ovr_o), 64'(m_ovr));
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_model();
  endtask

  task automatic press(int hold);
    btn_n = 1'b0;
    repeat (hold) tick();
    btn_n = 1'b1;
    repeat (DEB + 4) tick();
  endtask

  function automatic void chk_all_zero(string name);
    chk({name, "_cw"}, 64'(cw_o), 64'd0);
    chk({name, "_valid"}, 64'(valid_o), 64'd0);
    chk({name, "_staged"}, 64'(staged_o), 64'd0);
    chk({name, "_sel"}, 64'(sel_o), 64'd0);
    chk({name, "_count"}, 64'(cnt_o), 64'd0);
    chk({name, "_ovr"}, 64'(ovr_o), 64'd0);
  endfunction

  typedef struct {
    logic [SB-1:0] sel;
    logic [BB-1:0] data;
    logic [63:0]   exp_staged;
  } bank_vec_t;

  bank_vec_t vecs[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prev_cnt;
    int          last_e, commits;
    bit          found;
    int          btn_hold;

    vecs[0] = '{3'd0, 8'h11, 64'h0_0000_0011};
    vecs[1] = '{3'd1, 8'h22, 64'h0_0000_2211};
    vecs[2] = '{3'd2, 8'h33, 64'h0_0033_2211};
    vecs[3] = '{3'd3, 8'h44, 64'h0_4433_2211};
    vecs[4] = '{3'd4, 8'h01, 64'h1_4433_2211};
    vecs[5] = '{3'd5, 8'hAA, 64'h1_4433_2211};
    vecs[6] = '{3'd6, 8'hBB, 64'h1_4433_2211};
    vecs[7] = '{3'd4, 8'h00, 64'h0_4433_2211};
    vecs[8] = '{3'd4, 8'hFF, 64'h1_4433_2211};
    vecs[9] = '{3'd7, 8'hCC, 64'h1_4433_2211};

    rst_n = 1'b0; sw = '0; btn_n = 1'b1; run = 1'b0; clr = 1'b0; rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (6) tick();

    // ---- bank fill, table driven ----
    foreach (vecs[i]) begin
      sw = {vecs[i].sel, vecs[i].data};
      repeat (3) tick();
      chk("bank_fill_staged", 64'(staged_o), vecs[i].exp_staged);
      chk("bank_fill_sel", 64'(sel_o), 64'(vecs[i].sel));
      $display("[TB] bank sel=%0d data=0x%02h staged=0x%0h", vecs[i].sel, vecs[i].data, staged_o);
    end

    // ---- bounce then clean hold: exactly one commit ----
    for (int k = 0; k < 20; k++) begin
      btn_n = ((k / 2) % 2) != 0;
      tick();
    end
    btn_n = 1'b0;
    repeat (10) tick();
    chk("bounce_count", 64'(cnt_o), 64'd1);
    chk("bounce_cw", 64'(cw_o), 64'h1_4433_2211);
    chk("bounce_valid", 64'(valid_o), 64'd1);
    btn_n = 1'b1;
    repeat (DEB + 4) tick();
    chk("hold_valid", 64'(valid_o), 64'd1);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("accept_valid", 64'(valid_o), 64'd0);
    chk("accept_cw_held", 64'(cw_o), 64'h1_4433_2211);
    tick();
    chk("ready_ignored", 64'(valid_o), 64'd0);
    $display("[TB] bounce: count=%0d cw=0x%0h", cnt_o, cw_o);

    // ---- overrun ----
    press(DEB + 4);
    sw = {3'd0, 8'h77};
    repeat (3) tick();
    press(DEB + 4);
    chk("ovr_count", 64'(cnt_o), 64'd2);
    chk("ovr_cw_first", 64'(cw_o), 64'h1_4433_2211);
    chk("ovr_flag", 64'(ovr_o), 64'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovr_clear", 64'(ovr_o), 64'd0);
    btn_n = 1'b0;
    clr = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (m_preq) found = 1;
    end
    clr = 1'b0;
    chk("ovr_req_seen", 64'(found), 64'd1);
    chk("ovr_set_wins", 64'(ovr_o), 64'd1);
    tick();
    chk("ovr_sticky", 64'(ovr_o), 64'd1);
    btn_n = 1'b1;
    repeat (DEB + 4) tick();
    $display("[TB] overrun: count=%0d ovr=%0d", cnt_o, ovr_o);

    // ---- back-to-back accept in run mode ----
    rdy = 1'b1;
    tick();
    run = 1'b1;
    prev_cnt = cnt_o;
    last_e = -1;
    commits = 0;
    for (int e = 1; e <= 42; e++) begin
      tick();
      chk("b2b_valid", 64'(valid_o), 64'(cnt_o != prev_cnt));
      if (cnt_o != prev_cnt) begin
        commits++;
        if (last_e >= 0) chk("b2b_spacing", 64'(e - last_e), 64'd8);
        last_e = e;
        prev_cnt = cnt_o;
      end
    end
    chk("b2b_commits", 64'(commits), 64'd5);
    chk("b2b_count", 64'(cnt_o), 64'd7);
    run = 1'b0;
    repeat (4) tick();
    $display("[TB] run: commits=%0d count=%0d", commits, cnt_o);

    // ---- merged press + timer request ----
    prev_cnt = cnt_o;
    run = 1'b1;
    repeat (3) tick();
    btn_n = 1'b0;
    repeat (6) tick();
    chk("merge_before", 64'(cnt_o), 64'(prev_cnt));
    tick();
    chk("merge_count", 64'(cnt_o), 64'(prev_cnt + 16'd1));
    run = 1'b0;
    btn_n = 1'b1;
    repeat (10) tick();
    chk("merge_after", 64'(cnt_o), 64'(prev_cnt + 16'd1));
    $display("[TB] merge: count=%0d", cnt_o);

    // ---- asynchronous reset mid-debounce with a pending word ----
    rdy = 1'b0;
    press(DEB + 4);
    chk("pre_rst_valid", 64'(valid_o), 64'd1);
    btn_n = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("async_rst");
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < DEB; i++) begin
      tick();
      chk("rst_no_early_commit", 64'(cnt_o), 64'd0);
    end
    tick();
    chk("rst_press_commit", 64'(cnt_o), 64'd1);
    btn_n = 1'b1;
    repeat (DEB + 4) tick();
    $display("[TB] reset: count=%0d", cnt_o);

    // ---- randomized traffic against the model ----
    btn_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (btn_hold == 0) begin
        btn_n = ~btn_n;
        btn_hold = int'($urandom_range(1, 9));
      end
      btn_hold--;
      if ($urandom_range(0, 3) == 0) sw = SWW'($urandom);
      if ($urandom_range(0, 39) == 0) run = ~run;
      rdy = $urandom_range(0, 1) != 0;
      clr = $urandom_range(0, 15) == 0;
      tick();
    end
    $display("[TB] random: count=%0d ovr=%0d", cnt_o, ovr_o);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
